// File: rtl/axi_mem_pkg.sv
// Shared types for the AXI memory responder: FSM states, beat counter, LFSR constants.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
`include "mips_core.svh"

package axi_mem_pkg;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_BURST = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // AXI3 bursts carry at most 16 beats, so a 4-bit counter covers beats-1.
    typedef logic [3:0] beat_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as 0-based bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/mips_core.svh
// Core-wide bus widths shared by the core and its memory-side models.
// Latency: n/a (definitions only).
// Backpressure: n/a.
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`endif

// File: rtl/resp_lfsr.sv
// 16-bit Fibonacci LFSR used to randomise responder handshakes.
// Latency: new value every enabled cycle; seed reloaded one cycle after reset.
// Backpressure: none; free-running while en is high.
`include "mips_core.svh"

`ifdef AXI_RESP_BACKPRESSURE_EN
module resp_lfsr
    import axi_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] q
);

    // Shift left, feeding the tap parity into bit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {q[14:0], lfsr_feedback(q)};
        end
    end

endmodule
`endif

// File: rtl/axi_mem_responder.sv
// AXI3 slave memory model: independent read and write FSMs over a word-addressed array.
// Latency: first R beat READ_LATENCY+1 cycles after AR; B one cycle after the last W beat.
// Backpressure: VALIDs hold until handshake; AXI_RESP_BACKPRESSURE_EN adds LFSR-gated readies/beats.
`include "mips_core.svh"

module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int MEM_WORDS_LOG2 = 16,
    parameter int READ_LATENCY   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [3:0]             AWID,
    input  logic [3:0]             AWLEN,
    input  logic [`ADDR_WIDTH-1:0] AWADDR,
    input  logic                   WVALID,
    output logic                   WREADY,
    input  logic                   WLAST,
    input  logic [3:0]             WID,
    input  logic [`DATA_WIDTH-1:0] WDATA,
    output logic                   BVALID,
    input  logic                   BREADY,
    output logic [3:0]             BID,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    input  logic [3:0]             ARID,
    input  logic [3:0]             ARLEN,
    input  logic [`ADDR_WIDTH-1:0] ARADDR,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic                   RLAST,
    output logic [3:0]             RID,
    output logic [`DATA_WIDTH-1:0] RDATA
);

    localparam int    DEPTH    = 2 ** MEM_WORDS_LOG2;
    localparam beat_t LAT_LAST = beat_t'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    typedef logic [MEM_WORDS_LOG2-1:0] idx_t;

    logic [`DATA_WIDTH-1:0] mem [DEPTH];

    rd_state_t r_state, r_next;
    beat_t     r_len, r_beat, r_lat_cnt;
    logic [3:0] r_id;
    idx_t      r_idx;

    wr_state_t w_state, w_next;
    beat_t     w_len, w_beat;
    logic [3:0] w_id;
    idx_t      w_idx;

    logic bp_aw, bp_w, bp_ar, r_gate;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic r_last, w_last;

`ifdef AXI_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    logic        r_hold;
    logic        unused_lfsr;

    resp_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (lfsr_q)
    );

    assign bp_aw       = lfsr_q[0];
    assign bp_w        = lfsr_q[1];
    assign bp_ar       = lfsr_q[2];
    // First beat goes out immediately; later beats wait for the LFSR unless already presented.
    assign r_gate      = (r_beat == '0) | r_hold | lfsr_q[3];
    assign unused_lfsr = ^lfsr_q[15:4];

    // Remember a presented-but-unaccepted beat so RVALID cannot drop before its handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold <= 1'b0;
        end else if (r_hs) begin
            r_hold <= 1'b0;
        end else if (RVALID) begin
            r_hold <= 1'b1;
        end
    end
`else
    assign bp_aw  = 1'b1;
    assign bp_w   = 1'b1;
    assign bp_ar  = 1'b1;
    assign r_gate = 1'b1;
`endif

    assign ar_hs  = ARVALID & ARREADY;
    assign r_hs   = RVALID & RREADY;
    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;
    assign b_hs   = BVALID & BREADY;
    assign r_last = (r_beat == r_len);
    assign w_last = (w_beat == w_len);

    // Byte offsets and address bits above the array depth are don't-care; WID is not used.
    logic unused_bits;
    assign unused_bits = ^{WID,
                           AWADDR[`ADDR_WIDTH-1:MEM_WORDS_LOG2+2], AWADDR[1:0],
                           ARADDR[`ADDR_WIDTH-1:MEM_WORDS_LOG2+2], ARADDR[1:0]};

`ifdef SIMULATION
    // Give simulations a defined starting image; hardware contents are left unreset.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end
`endif

    // ---------------- read channel ----------------

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Read FSM next-state: wait out the latency, then stream until the last beat is taken.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = (READ_LATENCY == 0) ? R_BURST : R_WAIT;
            R_WAIT:  if (r_lat_cnt == LAT_LAST) r_next = R_BURST;
            R_BURST: if (r_hs && r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read channel outputs; data is read combinationally so a same-cycle write is not yet visible.
    always_comb begin
        ARREADY = (r_state == R_IDLE) & bp_ar;
        RVALID  = (r_state == R_BURST) & r_gate;
        RLAST   = RVALID & r_last;
        RID     = RVALID ? r_id : 4'd0;
        RDATA   = RVALID ? mem[r_idx] : '0;
    end

    // Read burst bookkeeping: latch the request, count latency, step index and beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id      <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_idx     <= '0;
            r_lat_cnt <= '0;
        end else begin
            if (ar_hs) begin
                r_id      <= ARID;
                r_len     <= ARLEN;
                r_idx     <= ARADDR[MEM_WORDS_LOG2+1:2];
                r_beat    <= '0;
                r_lat_cnt <= '0;
            end
            if (r_state == R_WAIT) r_lat_cnt <= r_lat_cnt + 4'd1;
            if (r_hs) begin
                r_idx  <= r_idx + MEM_WORDS_LOG2'(1);
                r_beat <= r_beat + 4'd1;
            end
        end
    end

    // ---------------- write channel ----------------

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Write FSM next-state: the beat count, not WLAST, ends the data phase.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write channel outputs.
    always_comb begin
        AWREADY = (w_state == W_IDLE) & bp_aw;
        WREADY  = (w_state == W_DATA) & bp_w;
        BVALID  = (w_state == W_RESP);
        BID     = BVALID ? w_id : 4'd0;
    end

    // Write burst bookkeeping: latch the request, step index and beat per accepted W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_id   <= '0;
            w_len  <= '0;
            w_beat <= '0;
            w_idx  <= '0;
        end else begin
            if (aw_hs) begin
                w_id   <= AWID;
                w_len  <= AWLEN;
                w_idx  <= AWADDR[MEM_WORDS_LOG2+1:2];
                w_beat <= '0;
            end
            if (w_hs) begin
                w_idx  <= w_idx + MEM_WORDS_LOG2'(1);
                w_beat <= w_beat + 4'd1;
            end
        end
    end

    // Array write port; contents survive reset, but no write lands during a reset cycle.
    always_ff @(posedge clk) begin
        if (rst_n && w_hs) mem[w_idx] <= WDATA;
    end

    wlast_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
        w_hs |-> (WLAST == w_last));

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with a transaction-level memory/timing model.
// Latency: checks first R beat at AR+5 and B one cycle after the last W beat.
// Backpressure: exercises RREADY stalls and a reset that abandons a read burst.
module tb_axi_mem_responder;

    localparam int LOG2  = 4;
    localparam int LAT   = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [3:0]  AWID, AWLEN, WID, BID, ARID, ARLEN, RID;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;

    always #5 clk = ~clk;

    axi_mem_responder #(.MEM_WORDS_LOG2(LOG2), .READ_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_rd_act = 0;
    int          m_rd_first, m_rd_idx, m_rd_beat, m_rd_len;
    logic [3:0]  m_rd_id;
    int          m_wr_ph = 0;   // 0 address, 1 data, 2 response
    int          m_wr_idx, m_wr_beat, m_wr_len;
    logic [3:0]  m_wr_id;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    end

    always @(negedge clk) begin
        bit e_arrdy, e_rvld, e_awrdy, e_wrdy, e_bvld;
        e_arrdy = !m_rd_act;
        e_rvld  = m_rd_act && (cyc >= m_rd_first);
        e_awrdy = (m_wr_ph == 0);
        e_wrdy  = (m_wr_ph == 1);
        e_bvld  = (m_wr_ph == 2);
        chk("ARREADY", ARREADY, e_arrdy);
        chk("RVALID",  RVALID,  e_rvld);
        chk("AWREADY", AWREADY, e_awrdy);
        chk("WREADY",  WREADY,  e_wrdy);
        chk("BVALID",  BVALID,  e_bvld);
        if (e_rvld) begin
            chk("RDATA", RDATA, m_mem[m_rd_idx]);
            chk("RID",   RID,   m_rd_id);
            chk("RLAST", RLAST, m_rd_beat == m_rd_len);
        end
        if (e_bvld) chk("BID", BID, m_wr_id);
        // What the coming clock edge does to the model.
        if (!rst_n) begin
            m_rd_act = 0;
            m_wr_ph  = 0;
        end else begin
            if (e_rvld && RREADY) begin
                if (m_rd_beat == m_rd_len) m_rd_act = 0;
                m_rd_beat++;
                m_rd_idx = (m_rd_idx + 1) % DEPTH;
            end else if (e_arrdy && ARVALID) begin
                m_rd_act   = 1;
                m_rd_first = cyc + 1 + LAT;
                m_rd_idx   = int'(ARADDR >> 2) % DEPTH;
                m_rd_beat  = 0;
                m_rd_len   = int'(ARLEN);
                m_rd_id    = ARID;
            end
            if (e_awrdy && AWVALID) begin
                m_wr_ph   = 1;
                m_wr_idx  = int'(AWADDR >> 2) % DEPTH;
                m_wr_beat = 0;
                m_wr_len  = int'(AWLEN);
                m_wr_id   = AWID;
            end else if (e_wrdy && WVALID) begin
                m_mem[m_wr_idx] = WDATA;
                m_wr_idx = (m_wr_idx + 1) % DEPTH;
                if (m_wr_beat == m_wr_len) m_wr_ph = 2;
                m_wr_beat++;
            end else if (e_bvld && BREADY) begin
                m_wr_ph = 0;
            end
        end
    end

    // ---------------- master-side drivers ----------------
    logic [31:0] wr_q [$];
    logic [31:0] rd_data [$];
    logic        rd_last [$];
    logic [3:0]  rd_ids [$];
    logic [3:0]  wr_bid;
    int          rd_lat;

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        int guard;
        bit hs;
        @(posedge clk); #1;
        AWVALID = 1; AWID = id; AWADDR = addr; AWLEN = len;
        hs = 0; guard = 0;
        while (!hs && guard < 50) begin
            @(negedge clk); guard++; hs = AWREADY;
            @(posedge clk); #1;
        end
        AWVALID = 0;
        for (int i = 0; i <= int'(len); i++) begin
            WVALID = 1; WDATA = wr_q[i]; WLAST = (i == int'(len));
            hs = 0; guard = 0;
            while (!hs && guard < 50) begin
                @(negedge clk); guard++; hs = WREADY;
                @(posedge clk); #1;
            end
        end
        WVALID = 0; WLAST = 0; BREADY = 1;
        hs = 0; guard = 0; wr_bid = 4'hF;
        while (!hs && guard < 50) begin
            @(negedge clk); guard++;
            if (BVALID) begin hs = 1; wr_bid = BID; end
            @(posedge clk); #1;
        end
        BREADY = 0;
        chk("wr_bresp_seen", hs, 1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int stall_beat);
        int guard, n, t_hs, stall_left;
        bit hs, stalled;
        rd_data.delete(); rd_last.delete(); rd_ids.delete();
        rd_lat = -1; n = 0; t_hs = 0; stall_left = 0; stalled = 0;
        @(posedge clk); #1;
        ARVALID = 1; ARID = id; ARADDR = addr; ARLEN = len;
        hs = 0; guard = 0;
        while (!hs && guard < 50) begin
            @(negedge clk); guard++;
            if (ARREADY) begin hs = 1; t_hs = cyc; end
            @(posedge clk); #1;
        end
        ARVALID = 0; RREADY = 1;
        guard = 0;
        while (n <= int'(len) && guard < 200) begin
            @(negedge clk); guard++;
            if (RVALID && rd_lat < 0) rd_lat = cyc - t_hs;
            if (RVALID && RREADY) begin
                rd_data.push_back(RDATA); rd_last.push_back(RLAST); rd_ids.push_back(RID);
                n++;
            end
            @(posedge clk); #1;
            if (n == stall_beat && !stalled) begin
                RREADY = 0; stall_left = 3; stalled = 1;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) RREADY = 1;
            end
        end
        RREADY = 0;
        chk("rd_beat_count", n, int'(len) + 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int guard;
        logic [31:0] old_val;
        AWVALID = 0; AWID = 0; AWLEN = 0; AWADDR = 0;
        WVALID = 0; WLAST = 0; WID = 0; WDATA = 0; BREADY = 0;
        ARVALID = 0; ARID = 0; ARLEN = 0; ARADDR = 0; RREADY = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_rvalid", RVALID, 0);  chk("rst_bvalid", BVALID, 0);
        chk("rst_rlast", RLAST, 0);    chk("rst_rid", RID, 0);
        chk("rst_bid", BID, 0);        chk("rst_rdata", RDATA, 0);
        chk("rst_arready", ARREADY, 1); chk("rst_awready", AWREADY, 1);
        chk("rst_wready", WREADY, 0);

        // Single write then read.
        wr_q = '{32'hDEADBEEF};
        do_write(4'd3, 32'h40, 4'd0);
        chk("t1_bid", wr_bid, 4'd3);
        do_read(4'd5, 32'h40, 4'd0, -1);
        chk("t1_rdata", rd_data[0], 32'hDEADBEEF);
        chk("t1_rlast", rd_last[0], 1);
        chk("t1_rid", rd_ids[0], 4'd5);
        chk("t1_latency", rd_lat, 5);

        // 4-beat burst, read back with a 3-cycle RREADY stall after beat 2.
        wr_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_write(4'd7, 32'h100, 4'd3);
        chk("t2_bid", wr_bid, 4'd7);
        do_read(4'd9, 32'h100, 4'd3, 2);
        chk("t2_d0", rd_data[0], 32'h11); chk("t2_d1", rd_data[1], 32'h22);
        chk("t2_d2", rd_data[2], 32'h33); chk("t2_d3", rd_data[3], 32'h44);
        chk("t2_last0", rd_last[0], 0); chk("t2_last1", rd_last[1], 0);
        chk("t2_last2", rd_last[2], 0); chk("t2_last3", rd_last[3], 1);
        chk("t2_rid", rd_ids[3], 4'd9);

        // Wrap from word 15 to word 0.
        wr_q = '{32'hF0F0000F, 32'h0000F0F0};
        do_write(4'd2, 32'h3C, 4'd1);
        do_read(4'd4, 32'h3C, 4'd1, -1);
        chk("t3_word15", rd_data[0], 32'hF0F0000F);
        chk("t3_word0_via_wrap", rd_data[1], 32'h0000F0F0);
        do_read(4'd4, 32'h0, 4'd0, -1);
        chk("t3_word0_direct", rd_data[0], 32'h0000F0F0);

        // Same-cycle read and write beat on word 5.
        wr_q = '{32'hAAAA0005};
        do_write(4'd1, 32'h14, 4'd0);
        @(posedge clk); #1;
        ARVALID = 1; ARID = 4'd6; ARADDR = 32'h14; ARLEN = 0;
        AWVALID = 1; AWID = 4'd8; AWADDR = 32'h14; AWLEN = 0;
        @(negedge clk);
        @(posedge clk); #1;
        ARVALID = 0; AWVALID = 0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!RVALID && guard < 50);
        chk("t4_rvalid_seen", RVALID, 1);
        @(posedge clk); #1;
        WVALID = 1; WDATA = 32'h55550005; WLAST = 1; RREADY = 1;
        @(negedge clk);
        old_val = RDATA;
        chk("t4_both_ready", {30'd0, WREADY, RVALID}, 32'd3);
        chk("t4_old_value", old_val, 32'hAAAA0005);
        @(posedge clk); #1;
        WVALID = 0; WLAST = 0; RREADY = 0; BREADY = 1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!BVALID && guard < 50);
        chk("t4_bid", BID, 4'd8);
        @(posedge clk); #1;
        BREADY = 0;
        do_read(4'd6, 32'h14, 4'd0, -1);
        chk("t4_new_value", rd_data[0], 32'h55550005);

        // Reset while beat 2 of a read burst is on the bus.
        @(posedge clk); #1;
        ARVALID = 1; ARID = 4'd10; ARADDR = 32'h100; ARLEN = 4'd3;
        @(negedge clk);
        @(posedge clk); #1;
        ARVALID = 0; RREADY = 1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!RVALID && guard < 50);
        chk("t5_beat1", RDATA, 32'h0000F0F0);
        @(posedge clk); #1;
        rst_n = 0;
        @(negedge clk);
        chk("t5_beat2_valid", RVALID, 1);
        chk("t5_beat2_data", RDATA, 32'h22);
        @(posedge clk); #1;
        rst_n = 1; RREADY = 0;
        @(negedge clk);
        chk("t5_rvalid_cleared", RVALID, 0);
        chk("t5_arready", ARREADY, 1);
        chk("t5_rlast", RLAST, 0);
        chk("t5_rid", RID, 0);
        do_read(4'd12, 32'h100, 4'd3, -1);
        chk("t5_fresh_d0", rd_data[0], 32'h0000F0F0);
        chk("t5_fresh_d1", rd_data[1], 32'h22);
        chk("t5_fresh_d3", rd_data[3], 32'h44);
        chk("t5_fresh_rid", rd_ids[0], 4'd12);
        chk("t5_fresh_latency", rd_lat, 5);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI3-style slave memory model answering the core's AXI master ports (AW/W/B write channels, AR/R read channels) from a word-addressed on-chip array. It sits outside the core in the FPGA/simulation top level and services the memory arbiter's bursts.
- Each direction runs its own FSM.
- At most one read burst and one write burst are in flight at a time.
- Optional randomised back-pressure exercises the arbiter and the caches.

## Interface
Parameters:
- MEM_WORDS_LOG2, 16: array depth is 2**MEM_WORDS_LOG2 words of `DATA_WIDTH bits.
- READ_LATENCY, 4: idle cycles between the AR handshake and the first R beat; range 0..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- AWVALID/AWREADY  in/out  1  write-address handshake.
- AWID  in  4  write transaction ID.
- AWLEN  in  4  beats-1.
- AWADDR  in  `ADDR_WIDTH  byte address.
- WVALID/WREADY  in/out  1  write-data handshake.
- WLAST  in  1  last beat.
- WID  in  4  ignored.
- WDATA  in  `DATA_WIDTH  write data.
- BVALID/BREADY  out/in  1  write-response handshake.
- BID  out  4  echoed AWID.
- ARVALID/ARREADY  in/out  1  read-address handshake.
- ARID  in  4  read ID.
- ARLEN  in  4  beats-1.
- ARADDR  in  `ADDR_WIDTH  byte address.
- RVALID/RREADY  out/in  1  read-data handshake.
- RLAST  out  1  final beat.
- RID  out  4  echoed ARID.
- RDATA  out  `DATA_WIDTH  read data.

## Operation
- Word index = ADDR[MEM_WORDS_LOG2+1:2]; byte-offset bits are ignored. Beats increment the word index by 1, wrapping modulo 2**MEM_WORDS_LOG2.
- Read FSM, states R_IDLE, R_WAIT, R_BURST:
  - R_IDLE: ARREADY=1. On ARVALID&&ARREADY, latch ARID, ARLEN and the index; clear the beat counter. Go to R_WAIT, or to R_BURST if READ_LATENCY==0.
  - R_WAIT: a counter counts READ_LATENCY cycles, then the FSM enters R_BURST.
  - R_BURST: RVALID=1, RDATA=mem[index], RID=latched ID, RLAST=(beat==len). On RREADY, advance the index and the beat counter. On the handshake of the last beat, return to R_IDLE.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: AWREADY=1. On handshake, latch AWID, AWLEN and the index.
  - W_DATA: WREADY=1. Each WVALID&&WREADY writes WDATA to mem[index] and advances the index and counter. The burst ends on beat==len regardless of WLAST; WLAST is checked only by assertion.
  - W_RESP: BVALID=1, BID=latched AWID, held until BREADY. Then W_IDLE.
- The two FSMs are fully independent and may run concurrently.
- A same-cycle write and read beat to the same word: RDATA shows the pre-write value. The write is visible from the next cycle.
- Once asserted, VALID outputs never drop before their handshake.
- Array contents are not reset. Under SIMULATION the array is zero-initialised at time 0.

## Timing
- Reset (rst_n low at a posedge): both FSMs return to IDLE, counters clear, and in-flight bursts are abandoned. From the following cycle: RVALID=0, BVALID=0, RLAST=0, RID=0, BID=0, RDATA=0, ARREADY=1, AWREADY=1, WREADY=0.
- Read latency: the AR handshake at cycle t gives the first RVALID at t+1+READ_LATENCY. Subsequent beats come every cycle while RREADY=1.
- Write: the AW handshake at t gives WREADY from t+1. After the last W handshake at u, BVALID=1 at u+1.
- A new AR (or AW) is accepted no earlier than the cycle after its FSM re-enters IDLE.

## Configuration
- AXI_RESP_BACKPRESSURE_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on reset) steps every cycle.
  - AWREADY, WREADY and ARREADY are additionally ANDed with LFSR bits 0, 1 and 2 respectively.
  - RVALID for each beat after the first waits for LFSR bit 3=1.
- Undefined: no LFSR exists, and the readies/beats follow the timing above exactly.

## Structure
- Package axi_mem_pkg: the read/write state enums, the LFSR seed and taps, and a beat-counter typedef (logic [3:0]). `ADDR_WIDTH and `DATA_WIDTH come from mips_core.svh.
- One sub-module, resp_lfsr (16-bit LFSR with enable), instantiated only under AXI_RESP_BACKPRESSURE_EN.

## Test plan
- Single write, then read: AW addr 0x40, len 0, WDATA 0xDEADBEEF, then AR 0x40 len 0. Expect BID=AWID, RDATA=0xDEADBEEF, RLAST=1, first RVALID 5 cycles after the AR handshake.
- 4-beat burst: write 0x11,0x22,0x33,0x44 at 0x100, then read len 3. Expect the same order, RLAST only on beat 4, and RID echoed.
- RREADY stalls: hold RREADY=0 for 3 cycles mid-burst. Expect RVALID held, RDATA stable, and no beat skipped.
- Wrap: with MEM_WORDS_LOG2=4, write a 2-beat burst at word 15. Expect the data at words 15 and 0.
- Concurrent read/write to the same word in the same cycle: RDATA shows the old value, and a later read shows the new value.
- Reset mid-burst: assert rst_n=0 during R_BURST beat 2. Expect RVALID=0 and ARREADY=1 the next cycle, and a fresh AR serviced normally.
